fibonacci_serializer: RTL

Rate converter that sits directly downstream of the two-per-cycle Fibonacci generator. It accepts one pair of consecutive terms per input handshake, buffers pairs in a small FIFO, and emits the terms one at a time over a valid/ready stream, first term of each pair first. It also flags 16-bit wrap-around in the emitted sequence, so single-rate consumers can run at one term per cycle and detect the overflow point.

---
 rtl/fibonacci_pkg.sv | 12 +
 rtl/fib_pair_fifo.sv | 50 +++++
 rtl/fibonacci_serializer.sv | 61 ++++++
 3 files changed

// File: rtl/fibonacci_pkg.sv
// Shared types and constants for the Fibonacci serializer slice.
// A pair holds two consecutive terms, with the earlier term in field a.
package fibonacci_pkg;

    localparam int TERM_WIDTH = 16;

    typedef struct packed {
        logic [TERM_WIDTH-1:0] a;
        logic [TERM_WIDTH-1:0] b;
    } fib_pair_t;

endpackage

// File: rtl/fib_pair_fifo.sv
// FIFO of term pairs built on power-of-two storage.
// The pointers carry one extra MSB so that full and empty can be told apart.
module fib_pair_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [2*WIDTH-1:0]       push_data,
    input  logic                     pop,
    output logic [2*WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               wr_en;
    logic               rd_en;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fibonacci_serializer.sv
// Serializes buffered Fibonacci term pairs into a one-term-per-cycle stream.
// It also flags the point where the emitted 16-bit sequence wraps around.
module fibonacci_serializer
    import fibonacci_pkg::*;
#(
    parameter int WIDTH = TERM_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_wrap,
    output logic [$clog2(DEPTH):0] level
);

    logic [2*WIDTH-1:0] head;
    logic               full;
    logic               empty;
    logic               sel;
    logic [WIDTH-1:0]   prev;
    logic               out_fire;

    fib_pair_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && !full),
        .push_data ({in_a, in_b}),
        .pop       (out_fire && sel),
        .head      (head),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = sel ? head[WIDTH-1:0] : head[2*WIDTH-1:WIDTH];
    // A term smaller than its predecessor can only arise from modular wrap-around.
    assign out_wrap  = out_valid && (out_data < prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel  <= 1'b0;
            prev <= '0;
        end else if (out_fire) begin
            sel  <= !sel;
            prev <= out_data;
        end
    end

endmodule
